// File: rtl/freq_histogram_x4.sv
// freq_histogram_x4
//
// Symbol-frequency histogram feeding the 4-input sort network of the
// canonical Huffman datapath. A block of symbols is counted into a table
// of NSYM saturating counters. The table is then drained four entries per
// beat as {count, symbol} words. Each drained entry is cleared as it leaves,
// so the table is zero again for the next block.
//
// Parameters
//   DSIZE   width of one packed entry {count, symbol}
//   OFFSET  symbol width; count width is DSIZE-OFFSET, NSYM = 2**OFFSET
//           (OFFSET >= 2 so that NSYM is a multiple of 4)
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   input symbol valid
//   in_ready   block accepts a symbol (high while counting)
//   in_sym     symbol value
//   in_last    final symbol of the block, qualified by in_valid && in_ready
//   out_valid  drain beat valid (high while draining)
//   out_ready  downstream accepts the beat
//   out_a0..3  entries {count[4*idx+k], 4*idx+k}, k = 0..3
//   out_last   final drain beat
//   overflow   sticky: some count saturated in the current block

module freq_histogram_x4 #(
    parameter int DSIZE  = 18,
    parameter int OFFSET = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OFFSET-1:0] in_sym,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DSIZE-1:0]  out_a0,
    output logic [DSIZE-1:0]  out_a1,
    output logic [DSIZE-1:0]  out_a2,
    output logic [DSIZE-1:0]  out_a3,
    output logic              out_last,
    output logic              overflow
);

    localparam int CW   = DSIZE - OFFSET;
    localparam int NSYM = 1 << OFFSET;
    localparam int IW   = OFFSET - 2;

    localparam logic [CW-1:0] CNT_MAX  = '1;
    localparam logic [IW-1:0] IDX_LAST = '1;

    typedef enum logic {
        COUNT,
        DRAIN
    } state_t;

    state_t          state;
    logic [IW-1:0]   idx;
    logic [CW-1:0]   counts [NSYM];

    // Counting, draining and read-and-clear share one process, because the
    // table is written by both phases.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= COUNT;
            idx      <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < NSYM; i++) begin
                counts[i] <= '0;
            end
        end else begin
            case (state)
                COUNT: begin
                    if (in_valid) begin
                        // Saturate rather than wrap, and remember it happened.
                        if (counts[in_sym] == CNT_MAX) begin
                            overflow <= 1'b1;
                        end else begin
                            counts[in_sym] <= counts[in_sym] + CW'(1);
                        end
                        if (in_last) begin
                            state <= DRAIN;
                            idx   <= '0;
                        end
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        // Clear the four entries leaving on this beat.
                        for (int k = 0; k < 4; k++) begin
                            counts[{idx, k[1:0]}] <= '0;
                        end
                        if (idx == IDX_LAST) begin
                            state    <= COUNT;
                            idx      <= '0;
                            overflow <= 1'b0;
                        end else begin
                            idx <= idx + IW'(1);
                        end
                    end
                end
                default: begin
                    state <= COUNT;
                end
            endcase
        end
    end

    // Handshake outputs decode only the state register, so there is no
    // combinational path between the input and output sides.
    assign in_ready  = (state == COUNT);
    assign out_valid = (state == DRAIN);
    assign out_last  = (state == DRAIN) && (idx == IDX_LAST);

    // The symbol field of each entry is its table address {idx, k}.
    assign out_a0 = {counts[{idx, 2'd0}], idx, 2'd0};
    assign out_a1 = {counts[{idx, 2'd1}], idx, 2'd1};
    assign out_a2 = {counts[{idx, 2'd2}], idx, 2'd2};
    assign out_a3 = {counts[{idx, 2'd3}], idx, 2'd3};

endmodule

// File: tb/tb_freq_histogram_x4.sv
// tb_freq_histogram_x4
//
// Directed bench for freq_histogram_x4 with default parameters. A small
// saturating count model supplies the full expected table; key beats are
// also compared against hand-computed constants.

module tb_freq_histogram_x4;

    localparam int NSYM  = 256;
    localparam int NBEAT = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_sym;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [17:0] out_a0;
    logic [17:0] out_a1;
    logic [17:0] out_a2;
    logic [17:0] out_a3;
    logic        out_last;
    logic        overflow;

    int total = 0;
    int bad   = 0;

    int          exp_count [NSYM];
    logic [17:0] cap [NBEAT][4];
    logic        cap_last [NBEAT];

    freq_histogram_x4 #(
        .DSIZE  (18),
        .OFFSET (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sym    (in_sym),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a0    (out_a0),
        .out_a1    (out_a1),
        .out_a2    (out_a2),
        .out_a3    (out_a3),
        .out_last  (out_last),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clearModel();
        for (int i = 0; i < NSYM; i++) exp_count[i] = 0;
    endtask

    // Present one symbol for one cycle; returns at the following negedge.
    task automatic applyStimulus(input logic [7:0] sym, input logic last);
        in_valid = 1'b1;
        in_sym   = sym;
        in_last  = last;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (exp_count[sym] < 1023) exp_count[sym]++;
    endtask

    // Drain one block into cap[]. While draining, in_valid is held high to
    // show it is ignored. Optional stall at stall_beat, optional reset at abort_beat.
    task automatic drainBlock(input int stall_beat, input int stall_cycles,
                              input int abort_beat, output int beats);
        int          wait_n;
        bit          stable;
        logic [72:0] snap;
        beats  = 0;
        wait_n = 0;
        while (!out_valid && wait_n < 16) begin
            @(negedge clk);
            wait_n++;
        end
        checkOutput("drain_start_valid", out_valid, 1);
        if (!out_valid) return;
        checkOutput("drain_in_ready", in_ready, 0);
        in_valid  = 1'b1;
        in_sym    = 8'h41;
        in_last   = 1'b0;
        out_ready = 1'b1;
        for (int b = 0; b < NBEAT; b++) begin
            if (b == abort_beat) begin
                rst_n = 1'b0;
                #1;
                checkOutput("abort_out_valid", out_valid, 0);
                checkOutput("abort_in_ready", in_ready, 1);
                in_valid  = 1'b0;
                out_ready = 1'b0;
                repeat (3) @(negedge clk);
                rst_n = 1'b1;
                clearModel();
                return;
            end
            if (b == stall_beat) begin
                out_ready = 1'b0;
                snap      = {out_a0, out_a1, out_a2, out_a3, out_last};
                stable    = 1'b1;
                repeat (stall_cycles) begin
                    @(negedge clk);
                    if ({out_a0, out_a1, out_a2, out_a3, out_last} !== snap || !out_valid)
                        stable = 1'b0;
                end
                checkOutput("stall_stable", 32'(stable), 1);
                out_ready = 1'b1;
            end
            cap[b][0]   = out_a0;
            cap[b][1]   = out_a1;
            cap[b][2]   = out_a2;
            cap[b][3]   = out_a3;
            cap_last[b] = out_last;
            if (out_valid) beats++;
            @(negedge clk);
        end
        checkOutput("drain_done_in_ready", in_ready, 1);
        checkOutput("drain_done_out_valid", out_valid, 0);
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    // Compare every captured beat against the model, then reset the model.
    task automatic checkTable(input string tag);
        int          errs;
        int          last_errs;
        logic [17:0] e;
        errs      = 0;
        last_errs = 0;
        for (int b = 0; b < NBEAT; b++) begin
            for (int k = 0; k < 4; k++) begin
                e = {10'(exp_count[4*b+k]), 8'(4*b+k)};
                if (cap[b][k] !== e) errs++;
            end
            if (cap_last[b] !== (b == NBEAT-1)) last_errs++;
        end
        checkOutput({tag, "_entries"}, errs, 0);
        checkOutput({tag, "_last"}, last_errs, 0);
        clearModel();
    endtask

    initial begin
        int beats;
        clearModel();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sym    = 8'h00;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] reset and idle");
        checkOutput("rst_in_ready", in_ready, 1);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_overflow", overflow, 0);
        checkOutput("rst_out_last", out_last, 0);
        repeat (10) @(negedge clk);
        checkOutput("idle_no_drain", out_valid, 0);

        $display("[TB] small block");
        applyStimulus(8'h41, 1'b0);
        applyStimulus(8'h41, 1'b0);
        applyStimulus(8'h00, 1'b0);
        applyStimulus(8'h41, 1'b0);
        applyStimulus(8'h41, 1'b1);
        drainBlock(-1, 0, -1, beats);
        checkOutput("small_beats", beats, 64);
        checkOutput("small_b0_a0", cap[0][0], 18'h00100);
        checkOutput("small_b0_a1", cap[0][1], 18'h00001);
        checkOutput("small_b16_a0", cap[16][0], 18'h00040);
        checkOutput("small_b16_a1", cap[16][1], 18'h00441);
        checkTable("small");

        $display("[TB] backpressure");
        applyStimulus(8'h41, 1'b0);
        applyStimulus(8'h41, 1'b0);
        applyStimulus(8'h00, 1'b0);
        applyStimulus(8'h41, 1'b0);
        applyStimulus(8'h41, 1'b1);
        drainBlock(16, 5, -1, beats);
        checkOutput("bp_beats", beats, 64);
        checkOutput("bp_b16_a1", cap[16][1], 18'h00441);
        checkOutput("bp_b17_a0", cap[17][0], 18'h00044);
        checkTable("bp");

        $display("[TB] saturation");
        for (int i = 1; i <= 1031; i++) begin
            applyStimulus(8'h05, (i == 1031));
            if (i == 1023) checkOutput("sat_ovf_before", overflow, 0);
            if (i == 1024) checkOutput("sat_ovf_set", overflow, 1);
        end
        checkOutput("sat_ovf_in_drain", overflow, 1);
        drainBlock(-1, 0, -1, beats);
        checkOutput("sat_b1_a1", cap[1][1], 18'h3FF05);
        checkOutput("sat_ovf_cleared", overflow, 0);
        checkTable("sat");

        $display("[TB] back-to-back blocks");
        applyStimulus(8'h10, 1'b0);
        applyStimulus(8'h10, 1'b1);
        drainBlock(-1, 0, -1, beats);
        checkOutput("blkA_b4_a0", cap[4][0], 18'h00210);
        checkTable("blkA");
        applyStimulus(8'h10, 1'b1);
        drainBlock(-1, 0, -1, beats);
        checkOutput("blkB_b4_a0", cap[4][0], 18'h00110);
        checkTable("blkB");

        $display("[TB] reset mid-drain");
        applyStimulus(8'h41, 1'b0);
        applyStimulus(8'h22, 1'b1);
        drainBlock(-1, 0, 10, beats);
        checkOutput("abort_state_count", in_ready, 1);
        applyStimulus(8'hFF, 1'b1);
        drainBlock(-1, 0, -1, beats);
        checkOutput("post_abort_b63_a3", cap[63][3], 18'h001FF);
        checkOutput("post_abort_b16_a1", cap[16][1], 18'h00041);
        checkTable("post_abort");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
